// File: rtl/mmio_avalon_bridge_pkg.sv
// Shared definitions for the MEM-stage MMIO bridge: FSM encoding, counter width,
// default UART window and an index-width helper.
package mmio_avalon_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam int          MMIO_TIMEOUT_W = 8;
  localparam logic [31:0] UART_BASE      = 32'h0000_0100;

  // Width of an index over n items; never zero so ports stay legal for n == 1.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mmio_avalon_bridge_decoder.sv
// Combinational window decode: byte address -> hit, channel index, word offset.
module mmio_addr_decoder
  import mmio_avalon_bridge_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter logic [31:0] BASE_ADDR = UART_BASE,
  parameter int          WIN_BYTES = 8,
  parameter int          CH_W      = idx_w(N_CH),
  parameter int          OFF_W     = idx_w(WIN_BYTES / 4)
) (
  input  logic             req_valid,
  input  logic             req_read,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  output logic             hit,
  output logic [CH_W-1:0]  ch,
  output logic [OFF_W-1:0] offset
);

  localparam int          WIN_LSB = $clog2(WIN_BYTES);
  localparam logic [32:0] LO      = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI      = LO + 33'(N_CH * WIN_BYTES);

  logic [31:0] rel;
  logic        in_range;
  logic        unused_bits;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  assign in_range    = ({1'b0, req_addr} >= LO) && ({1'b0, req_addr} < HI);
  assign hit         = req_valid & (req_read | req_write) & in_range;
  assign rel         = req_addr - BASE_ADDR;
  assign unused_bits = ^{rel, req_addr};

  generate
    if (N_CH > 1) begin : g_ch
      assign ch = rel[WIN_LSB +: CH_W];
    end else begin : g_ch_single
      assign ch = '0;
    end
    if (WIN_BYTES > 4) begin : g_off
      assign offset = req_addr[WIN_LSB-1:2];
    end else begin : g_off_single
      assign offset = '0;
    end
  endgenerate

endmodule

// File: rtl/mmio_avalon_bridge.sv
// MEM-stage bridge from core loads/stores to N Avalon-MM slaves: registered
// IDLE/ACCESS/DONE handshake with a saturating timeout that raises bus_error.
module mmio_avalon_bridge
  import mmio_avalon_bridge_pkg::*;
#(
  parameter int          N_CH      = 2,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = UART_BASE,
  parameter int          WIN_BYTES = 8,
  parameter int          TIMEOUT   = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  input  logic                            req_read,
  input  logic                            req_write,
  input  logic [31:0]                     req_addr,
  input  logic [DATA_W-1:0]               req_wdata,
  input  logic                            pipe_advance,
  output logic                            hit,
  output logic                            core_stall,
  output logic                            rsp_valid,
  output logic [DATA_W-1:0]               rsp_rdata,
  output logic                            bus_error,
  output logic [N_CH-1:0]                 av_chipselect,
  output logic [idx_w(WIN_BYTES/4)-1:0]   av_address,
  output logic                            av_read_n,
  output logic                            av_write_n,
  output logic [DATA_W-1:0]               av_writedata,
  input  logic [N_CH*DATA_W-1:0]          av_readdata,
  input  logic [N_CH-1:0]                 av_waitrequest
);

  localparam int CH_W  = idx_w(N_CH);
  localparam int OFF_W = idx_w(WIN_BYTES / 4);

  state_e                    state_q, state_d;
  logic [MMIO_TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]           ch_q, ch_d, dec_ch;
  logic [OFF_W-1:0]          off_q, off_d, dec_off;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic [DATA_W-1:0]         rdata_q, rdata_d;
  logic                      wr_q, wr_d;
  logic                      err_q, err_d;
  logic [DATA_W-1:0]         rd_sel;
  logic                      wait_sel;

  mmio_addr_decoder #(
    .N_CH      (N_CH),
    .BASE_ADDR (BASE_ADDR),
    .WIN_BYTES (WIN_BYTES),
    .CH_W      (CH_W),
    .OFF_W     (OFF_W)
  ) u_dec (
    .req_valid (req_valid),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .hit       (hit),
    .ch        (dec_ch),
    .offset    (dec_off)
  );

  // Only the latched channel's wait/data matter; other channels are ignored.
  assign rd_sel   = av_readdata[int'(ch_q)*DATA_W +: DATA_W];
  assign wait_sel = av_waitrequest[ch_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit) begin
          ch_d    = dec_ch;
          off_d   = dec_off;
          wdata_d = req_wdata;
          wr_d    = req_write;
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // cnt_q counts completed wait cycles, so the abort lands on ACCESS cycle TIMEOUT.
        if (!wait_sel) begin
          rdata_d = wr_q ? '0 : rd_sel;
          state_d = ST_DONE;
        end else if (int'(cnt_q) + 1 >= TIMEOUT) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (pipe_advance) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    av_chipselect = '0;
    for (int i = 0; i < N_CH; i++)
      av_chipselect[i] = (state_q == ST_ACCESS) && (ch_q == CH_W'(i));
  end

  assign av_read_n    = !((state_q == ST_ACCESS) && !wr_q);
  assign av_write_n   = !((state_q == ST_ACCESS) &&  wr_q);
  assign av_address   = off_q;
  assign av_writedata = wdata_q;
  assign rsp_valid    = (state_q == ST_DONE);
  assign rsp_rdata    = rdata_q;
  assign bus_error    = err_q;
  assign core_stall   = ((state_q == ST_IDLE) && hit) || (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mmio_avalon_bridge.sv
// Directed bench for mmio_avalon_bridge: expected read data is queued at issue
// and popped when rsp_valid appears; all checks are immediate assertions.
module tb_mmio_avalon_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0, pipe_advance = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        hit, core_stall, rsp_valid, bus_error, av_read_n, av_write_n;
  logic [31:0] rsp_rdata, av_writedata;
  logic [1:0]  av_chipselect;
  logic [0:0]  av_address;
  logic [63:0] av_readdata;
  logic [1:0]  av_waitrequest = 2'b00;
  logic [31:0] ch_data [2] = '{32'h0000_0041, 32'hC0DE_0001};

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] sb[$];

  assign av_readdata = {ch_data[1], ch_data[0]};

  always #5 clk = ~clk;

  mmio_avalon_bridge #(
    .N_CH(2), .DATA_W(32), .BASE_ADDR(32'h100), .WIN_BYTES(8), .TIMEOUT(255)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .pipe_advance   (pipe_advance),
    .hit            (hit),
    .core_stall     (core_stall),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .bus_error      (bus_error),
    .av_chipselect  (av_chipselect),
    .av_address     (av_address),
    .av_read_n      (av_read_n),
    .av_write_n     (av_write_n),
    .av_writedata   (av_writedata),
    .av_readdata    (av_readdata),
    .av_waitrequest (av_waitrequest)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"},    av_chipselect, 2'b00);
    chk({tag, "_rdn"},   av_read_n, 1'b1);
    chk({tag, "_wrn"},   av_write_n, 1'b1);
    chk({tag, "_addr"},  av_address, 1'b0);
    chk({tag, "_wdata"}, av_writedata, 32'h0);
    chk({tag, "_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_berr"},  bus_error, 1'b0);
  endtask

  // One complete transaction: issue, walk ACCESS, check DONE, hold, retire.
  task automatic do_access(input logic [31:0] addr, input logic rd, input logic wr,
                           input logic [31:0] wd, input int waits, input int adv_delay);
    int          ch, k, exp_cyc;
    logic        exp_err, bad;
    logic [31:0] exp_rd, got_exp;
    logic [1:0]  exp_cs;
    ch      = int'((addr - 32'h100) >> 3);
    exp_err = (waits >= 255);
    exp_cyc = exp_err ? 255 : waits + 1;
    exp_rd  = (wr || exp_err) ? 32'h0 : ch_data[ch];
    exp_cs  = 2'b01 << ch;

    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = addr; req_read = rd; req_write = wr; req_wdata = wd;
    pipe_advance = 1'b0;
    av_waitrequest = 2'b11;
    av_waitrequest[ch] = (waits > 0);
    sb.push_back(exp_rd);
    @(negedge clk);
    chk("issue_hit", hit, 1'b1);
    chk("issue_stall", core_stall, 1'b1);
    chk("issue_cs", av_chipselect, 2'b00);

    k = 1; bad = 1'b0;
    forever begin
      @(posedge clk); #1;
      av_waitrequest[ch] = (k <= waits);
      @(negedge clk);
      if (rsp_valid || k > 400) break;
      if (av_chipselect !== exp_cs || av_address !== addr[2] || core_stall !== 1'b1 ||
          av_read_n !== wr || av_write_n !== !wr || (wr && av_writedata !== wd))
        bad = 1'b1;
      k++;
    end
    chk("access_cycles", k - 1, exp_cyc);
    chk("access_signals", bad, 1'b0);

    got_exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
    chk("done_valid", rsp_valid, 1'b1);
    chk("done_rdata", rsp_rdata, got_exp);
    chk("done_berr", bus_error, exp_err);
    chk("done_stall", core_stall, 1'b0);
    chk("done_bus_idle", {av_chipselect, av_read_n, av_write_n}, 4'b0011);

    for (int d = 0; d < adv_delay; d++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_rdata", rsp_rdata, got_exp);
      chk("hold_berr", bus_error, 1'b0);
      chk("hold_no_reissue", {av_chipselect, av_read_n, av_write_n}, 4'b0011);
    end
    pipe_advance = 1'b1;

    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; pipe_advance = 1'b0;
    av_waitrequest = 2'b00;
    @(negedge clk);
    chk("retired", {rsp_valid, core_stall, av_chipselect}, 4'b0000);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    chk("reset_stall", core_stall, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ch0 read, no wait
    do_access(32'h104, 1'b1, 1'b0, 32'h0, 0, 0);
    // ch1 write, 3 wait cycles; ch0 waitrequest held high and ignored
    do_access(32'h108, 1'b0, 1'b1, 32'hA5, 3, 0);
    // last word of last window, held DONE for 2 extra cycles
    do_access(32'h10C, 1'b1, 1'b0, 32'h0, 1, 2);
    // read and write both set: write wins
    do_access(32'h100, 1'b1, 1'b1, 32'h1234_5678, 0, 0);

    // reset in the middle of ACCESS
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h104; req_wdata = 32'hDEAD_BEEF;
    av_waitrequest = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_cs", av_chipselect, 2'b01);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0; req_read = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    av_waitrequest = 2'b00;
    @(negedge clk);
    chk("postrst_valid", {rsp_valid, av_chipselect}, 3'b000);

    // waitrequest stuck: abort after 255 ACCESS cycles
    do_access(32'h104, 1'b1, 1'b0, 32'h0, 1000, 1);

    // misses
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h110;
    @(negedge clk);
    chk("miss_hi", {hit, core_stall, av_chipselect, av_read_n}, 5'b00001);
    @(posedge clk); #1;
    req_addr = 32'h0FC;
    @(negedge clk);
    chk("miss_lo", {hit, core_stall, av_chipselect, av_read_n}, 5'b00001);
    @(posedge clk); #1;
    @(negedge clk);
    chk("miss_no_rsp", {rsp_valid, av_chipselect}, 3'b000);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = 32'h104;
    @(negedge clk);
    chk("no_valid_no_hit", {hit, core_stall}, 2'b00);
    req_read = 1'b0;

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
